// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared widths, load-format enum and bin/gray conversion functions
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH     = 32;

  // Widest word the helpers handle; narrower callers zero-extend in and truncate out.
  // Zero upper bits change neither conversion's lower bits.
  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  typedef enum logic {
    FMT_BIN  = 1'b0,
    FMT_GRAY = 1'b1
  } load_fmt_e;

  function automatic gray_word_t bin2gray(input gray_word_t value);
    return value ^ (value >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it, taken from the MSB down.
  function automatic gray_word_t gray2bin(input gray_word_t value);
    gray_word_t result;
    result = '0;
    result[GRAY_MAX_WIDTH-1] = value[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      result[i] = result[i+1] ^ value[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// rtl/gray_conv.sv - combinational bin<->gray converter; mode selects the format of din
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  load_fmt_e        mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // mode = FMT_BIN: din is binary, dout is its Gray code.
  // mode = FMT_GRAY: din is Gray, dout is its binary value.
  always_comb begin
    dout = '0;
    if (mode == FMT_GRAY) begin
      dout = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(din)));
    end else begin
      dout = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(din)));
    end
  end

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered Gray/binary up/down counter with load and wrap pulse (GRAY_COUNTER_SAT_EN selects saturation)
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH             = GRAY_DEFAULT_WIDTH,
  parameter int LOAD_GRAY_DEFAULT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_fmt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  output logic [WIDTH-1:0] changed
);

  logic [WIDTH-1:0] bin_q, gray_q, changed_q;
  logic             wrap_q;

  logic [WIDTH-1:0] bin_n, gray_n, changed_n;
  logic             wrap_n;

  load_fmt_e        conv_mode;
  logic [WIDTH-1:0] conv_out;
  logic [WIDTH-1:0] load_bin, load_gray;

  logic [WIDTH-1:0] step_bin, step_gray;
  logic             at_boundary;

  // A nonzero LOAD_GRAY_DEFAULT makes din Gray even when load_fmt is tied low,
  // so a harness that never drives load_fmt can still load Gray values.
  assign conv_mode = (load_fmt || (LOAD_GRAY_DEFAULT != 0)) ? FMT_GRAY : FMT_BIN;

  gray_conv #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .mode (conv_mode),
    .din  (din),
    .dout (conv_out)
  );

  // din supplies one representation of the load value; the converter supplies the other.
  assign load_bin  = (conv_mode == FMT_GRAY) ? conv_out : din;
  assign load_gray = (conv_mode == FMT_GRAY) ? din      : conv_out;

  assign step_bin    = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
  assign step_gray   = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(step_bin)));
  assign at_boundary = up ? (&bin_q) : (bin_q == '0);

  // Next-state selection: load beats count; idle holds the count and clears the pulses.
  always_comb begin
    bin_n     = bin_q;
    gray_n    = gray_q;
    wrap_n    = 1'b0;
    changed_n = '0;
    if (load) begin
      bin_n     = load_bin;
      gray_n    = load_gray;
      changed_n = gray_q ^ load_gray;
    end else if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (at_boundary) begin
        wrap_n = 1'b1;
      end else begin
        bin_n     = step_bin;
        gray_n    = step_gray;
        changed_n = gray_q ^ step_gray;
      end
`else
      bin_n     = step_bin;
      gray_n    = step_gray;
      wrap_n    = at_boundary;
      changed_n = gray_q ^ step_gray;
`endif
    end
  end

  // State register; reset overrides any concurrent load or count.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q     <= '0;
      gray_q    <= '0;
      wrap_q    <= 1'b0;
      changed_q <= '0;
    end else begin
      bin_q     <= bin_n;
      gray_q    <= gray_n;
      wrap_q    <= wrap_n;
      changed_q <= changed_n;
    end
  end

  assign gray    = gray_q;
  assign bin     = bin_q;
  assign wrap    = wrap_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed vector bench for gray_counter (both GRAY_COUNTER_SAT_EN builds)
module tb_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, en, up, load, load_fmt;
  logic [W-1:0] din;
  logic [W-1:0] gray, bin, changed;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic         load_fmt;
    logic [W-1:0] din;
    logic [W-1:0] exp_gray;
    logic [W-1:0] exp_bin;
    logic         exp_wrap;
    logic [W-1:0] exp_changed;
  } vec_t;

  vec_t vecs[17];

  gray_counter #(
    .WIDTH             (W),
    .LOAD_GRAY_DEFAULT (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_fmt (load_fmt),
    .din      (din),
    .gray     (gray),
    .bin      (bin),
    .wrap     (wrap),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic u, input logic l,
                              input logic f, input logic [W-1:0] d, input logic [W-1:0] g,
                              input logic [W-1:0] b, input logic w, input logic [W-1:0] c);
    vec_t v;
    v.reset = r; v.en = e; v.up = u; v.load = l; v.load_fmt = f; v.din = d;
    v.exp_gray = g; v.exp_bin = b; v.exp_wrap = w; v.exp_changed = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] g, input logic [W-1:0] b,
                       input logic w, input logic [W-1:0] c);
    checks++;
    if (gray !== g || bin !== b || wrap !== w || changed !== c) begin
      errors++;
      $display("FAIL %s: got gray=%b bin=%b wrap=%b changed=%b, expected gray=%b bin=%b wrap=%b changed=%b",
               name, gray, bin, wrap, changed, g, b, w, c);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic f, input logic [W-1:0] d);
    @(negedge clk);
    reset = r; en = e; up = u; load = l; load_fmt = f; din = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] gray_seq[16];
  logic [W-1:0] prev_gray;
  logic [W-1:0] diff;

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_fmt = 1'b0; din = '0;

    //                r  en up ld fmt din       gray     bin      wrap changed
    vecs[0]  = mk(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    vecs[1]  = mk(0, 0, 0, 1, 0, 4'b1100, 4'b1010, 4'b1100, 0, 4'b1010);
    vecs[2]  = mk(0, 0, 0, 1, 1, 4'b1010, 4'b1010, 4'b1100, 0, 4'b0000);
    vecs[3]  = mk(0, 1, 1, 0, 0, 4'b0000, 4'b1011, 4'b1101, 0, 4'b0001);
    vecs[4]  = mk(0, 1, 1, 0, 0, 4'b0000, 4'b1001, 4'b1110, 0, 4'b0010);
    vecs[5]  = mk(0, 1, 0, 0, 0, 4'b0000, 4'b1011, 4'b1101, 0, 4'b0010);
    vecs[6]  = mk(1, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
`ifdef GRAY_COUNTER_SAT_EN
    vecs[7]  = mk(0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    vecs[8]  = mk(0, 1, 1, 0, 0, 4'b0000, 4'b0001, 4'b0001, 0, 4'b0001);
    vecs[9]  = mk(0, 1, 1, 1, 0, 4'b0101, 4'b0111, 4'b0101, 0, 4'b0110);
`else
    vecs[7]  = mk(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 4'b1111, 1, 4'b1000);
    vecs[8]  = mk(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b1000);
    vecs[9]  = mk(0, 1, 1, 1, 0, 4'b0101, 4'b0111, 4'b0101, 0, 4'b0111);
`endif
    vecs[10] = mk(1, 1, 1, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000);
    vecs[11] = mk(0, 0, 0, 1, 1, 4'b1000, 4'b1000, 4'b1111, 0, 4'b1000);
    vecs[12] = mk(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 4'b1111, 0, 4'b0000);
    vecs[13] = mk(0, 0, 0, 0, 0, 4'b0000, 4'b1000, 4'b1111, 0, 4'b0000);
    vecs[14] = mk(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 4'b1111, 0, 4'b0000);
`ifdef GRAY_COUNTER_SAT_EN
    vecs[15] = mk(0, 1, 1, 0, 0, 4'b0000, 4'b1000, 4'b1111, 1, 4'b0000);
    vecs[16] = mk(0, 1, 0, 0, 0, 4'b0000, 4'b1001, 4'b1110, 0, 4'b0001);
`else
    vecs[15] = mk(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b1000);
    vecs[16] = mk(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 4'b1111, 1, 4'b1000);
`endif

    gray_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].reset, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_fmt, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp_gray, vecs[i].exp_bin,
            vecs[i].exp_wrap, vecs[i].exp_changed);
    end

    // Full upward walk from reset: Gray sequence, single-bit steps, wrap only at rollover.
    drive(1, 0, 1, 0, 0, 4'b0000);
    check("walk_reset", 4'b0000, 4'b0000, 1'b0, 4'b0000);
    prev_gray = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 1, 0, 0, 4'b0000);
      check($sformatf("walk%0d", i), gray_seq[i], W'(i + 1), 1'b0, prev_gray ^ gray_seq[i]);
      diff = prev_gray ^ gray;
      checks++;
      if ($countones(diff) != 1) begin
        errors++;
        $display("FAIL walk%0d_onehot: toggled=%b, required exactly one bit", i, diff);
      end
      prev_gray = gray_seq[i];
    end
    drive(0, 1, 1, 0, 0, 4'b0000);
`ifdef GRAY_COUNTER_SAT_EN
    check("walk_top", 4'b1000, 4'b1111, 1'b1, 4'b0000);
`else
    check("walk_top", 4'b0000, 4'b0000, 1'b1, 4'b1000);
`endif

`ifdef GRAY_COUNTER_SAT_EN
    // Saturation holds at the top for consecutive up steps.
    drive(0, 0, 1, 1, 0, 4'b1111);
    check("sat_load", 4'b1000, 4'b1111, 1'b0, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 0, 4'b0000);
      check($sformatf("sat_hit%0d", i), 4'b1000, 4'b1111, 1'b1, 4'b0000);
    end
`else
    // Descending from one to zero, then across the bottom.
    drive(0, 0, 1, 1, 0, 4'b0001);
    check("down_load", 4'b0001, 4'b0001, 1'b0, 4'b0001);
    drive(0, 1, 0, 0, 0, 4'b0000);
    check("down_zero", 4'b0000, 4'b0000, 1'b0, 4'b0001);
    drive(0, 1, 0, 0, 0, 4'b0000);
    check("down_wrap", 4'b1000, 4'b1111, 1'b1, 4'b1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
